// File: rtl/ibex_simple_system_dside_pkg.sv
// Shared types and helpers for the simple-system data-side responder.
//   dside_resp_t   : one response slot (valid, err, rdata) carried down the
//                    response pipeline.
//   DsideRespIdle  : the all-zero, not-valid response.
//   addr_in_range  : 1 when base <= addr < base + 4*words; the limit is
//                    computed 34 bits wide so a window ending at 4 GiB does
//                    not wrap.
package ibex_simple_system_dside_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } dside_resp_t;

    localparam dside_resp_t DsideRespIdle = '{valid: 1'b0, err: 1'b0, rdata: 32'h0000_0000};

    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] words);
        logic [33:0] limit_s;
        limit_s = {2'b00, base} + {words, 2'b00};
        return (addr >= base) && ({2'b00, addr} < limit_s);
    endfunction

endpackage

// File: rtl/ibex_simple_system_dside_resp_pipe.sv
// Fixed-latency response pipeline. A response pushed at a clock edge appears
// on head_resp exactly Depth cycles later. All stages are cleared by a
// synchronous active-low reset, so in-flight responses are dropped.
//   clk_i     : clock
//   rst_ni    : synchronous active-low clear
//   push_resp : response entering the pipe (valid=0 when nothing granted)
//   head_resp : registered response leaving the pipe
module ibex_simple_system_dside_resp_pipe
    import ibex_simple_system_dside_pkg::*;
#(
    parameter int Depth = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  dside_resp_t push_resp,
    output dside_resp_t head_resp
);

    dside_resp_t stage_r [Depth];

    // Shift responses one stage per cycle; reset empties every stage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                stage_r[i] <= DsideRespIdle;
            end
        end else begin
            stage_r[0] <= push_resp;
            for (int i = 1; i < Depth; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign head_resp = stage_r[Depth-1];

endmodule

// File: rtl/ibex_simple_system_dside_responder.sv
// Memory-side responder for the simple-system host data bus (req/gnt/rvalid).
// Grants requests unless stalled or at the outstanding limit, commits
// byte-enabled stores at the grant edge, and answers every grant exactly
// RespLatency cycles later, in order.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   stall_i            : forces gnt_o low
//   req_i / gnt_o      : request handshake (gnt_o is combinational)
//   we_i, addr_i, be_i, wdata_i : request attributes
//   rvalid_o, rdata_o, err_o    : registered response, data/err 0 when idle
module ibex_simple_system_dside_responder
    import ibex_simple_system_dside_pkg::*;
#(
    parameter logic [31:0] AddrBase       = 32'h0010_0000,
    parameter int          MemWords       = 1024,
    parameter int          RespLatency    = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [31:0]     mem_r [MemWords];
    logic [CntW-1:0] count_r;
    logic            gnt_s;
    logic            in_range_s;
    logic [31:0]     offset_s;
    logic [IdxW-1:0] idx_s;
    logic            unused_addr_s;
    dside_resp_t     new_resp_s;
    dside_resp_t     head_resp_s;

    assign in_range_s    = addr_in_range(addr_i, AddrBase, 32'(MemWords));
    assign offset_s      = addr_i - AddrBase;
    // Word index keeps only the bits that address the array.
    assign idx_s         = offset_s[IdxW+1:2];
    assign unused_addr_s = ^{offset_s[31:IdxW+2], offset_s[1:0]};

    // Grant when not stalled and a slot is free, counting a slot that a
    // response retiring this cycle gives back.
    always_comb begin
        gnt_s = 1'b0;
        if (rst_ni && req_i && !stall_i) begin
            if ((count_r < MaxCnt) || head_resp_s.valid) begin
                gnt_s = 1'b1;
            end else begin
                gnt_s = 1'b0;
            end
        end else begin
            gnt_s = 1'b0;
        end
    end

    // Build the response for this cycle's grant; loads sample the word now.
    always_comb begin
        new_resp_s = DsideRespIdle;
        if (gnt_s) begin
            new_resp_s.valid = 1'b1;
            if (!in_range_s) begin
                new_resp_s.err = 1'b1;
            end else if (!we_i) begin
                new_resp_s.rdata = mem_r[idx_s];
            end else begin
                new_resp_s.rdata = 32'h0000_0000;
            end
        end else begin
            new_resp_s = DsideRespIdle;
        end
    end

    // Commit enabled store lanes at the grant edge; memory is never reset.
    always_ff @(posedge clk_i) begin
        if (gnt_s && we_i && in_range_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem_r[idx_s][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Track granted-but-unanswered transactions.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_r <= {CntW{1'b0}};
        end else begin
            case ({gnt_s, head_resp_s.valid})
                2'b10:   count_r <= count_r + CntOne;
                2'b01:   count_r <= count_r - CntOne;
                default: count_r <= count_r;
            endcase
        end
    end

    ibex_simple_system_dside_resp_pipe #(
        .Depth (RespLatency)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_resp (new_resp_s),
        .head_resp (head_resp_s)
    );

    assign gnt_o    = gnt_s;
    assign rvalid_o = head_resp_s.valid;
    assign err_o    = head_resp_s.err;
    assign rdata_o  = head_resp_s.rdata;

endmodule

// File: tb/tb_ibex_simple_system_dside_responder.sv
// Bench for the data-side responder: instance 0 uses default parameters,
// instance 1 uses RespLatency=3, MaxOutstanding=1. A scoreboard pushes the
// expected response at each observed grant (computed from a word-array model
// of memory) and a monitor pops and compares whenever rvalid is seen.
module tb_ibex_simple_system_dside_responder;

    localparam logic [31:0]     BASE  = 32'h0010_0000;
    localparam int              WORDS = 1024;
    localparam longint unsigned LO    = 64'h0000_0000_0010_0000;
    localparam longint unsigned HI    = LO + 64'd4 * 64'd1024;
    localparam int LAT0 = 1, MAX0 = 2, LAT1 = 3, MAX1 = 1;

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk, rst_n;
    logic        stall [2];
    logic        req   [2];
    logic        we    [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic        err   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  be    [2];

    exp_t        sb_q [2][$];
    logic [31:0] mem_m [longint unsigned];
    int unsigned cyc;
    int          comp_cnt, fail_cnt;
    bit          armed;

    ibex_simple_system_dside_responder #(
        .AddrBase(BASE), .MemWords(WORDS), .RespLatency(LAT0), .MaxOutstanding(MAX0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .we_i(we[0]), .addr_i(addr[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    ibex_simple_system_dside_responder #(
        .AddrBase(BASE), .MemWords(WORDS), .RespLatency(LAT1), .MaxOutstanding(MAX1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .we_i(we[1]), .addr_i(addr[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int maxo_of(input int k);
        return (k == 0) ? MAX0 : MAX1;
    endfunction

    function automatic logic [31:0] pool_addr(input int i);
        return (i < 8) ? BASE + 32'(4 * i) : BASE + 32'(4 * (WORDS - 1));
    endfunction

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        comp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, k, cyc, act, exp);
        end
    endfunction

    // Reference model: what the responder must answer for the request granted now.
    function automatic void model_push(input int k);
        longint unsigned la, key;
        logic [31:0] w;
        exp_t e;
        la      = {32'h0000_0000, addr[k]};
        e.due   = cyc + lat_of(k);
        e.err   = 1'b0;
        e.rdata = 32'h0000_0000;
        if (la < LO || la >= HI) begin
            e.err = 1'b1;
        end else begin
            key = (longint'(k) << 32) | ((la - LO) >> 2);
            w   = mem_m.exists(key) ? mem_m[key] : 32'h0000_0000;
            if (we[k]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
                end
                mem_m[key] = w;
            end else begin
                e.rdata = w;
            end
        end
        sb_q[k].push_back(e);
    endfunction

    // Monitor: check grants, pop/compare responses, push expectations on grant.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic eg;
                exp_t e;
                eg = rst_n && req[k] && !stall[k] &&
                     ((sb_q[k].size() < maxo_of(k)) || (rvalid[k] === 1'b1));
                chk("gnt", k, {31'd0, gnt[k]}, {31'd0, eg});
                if (rvalid[k] === 1'b1) begin
                    if (sb_q[k].size() == 0) begin
                        chk("unexpected_rvalid", k, 32'd1, 32'd0);
                    end else begin
                        e = sb_q[k].pop_front();
                        chk("resp_cycle", k, 32'(cyc), 32'(e.due));
                        chk("resp_err", k, {31'd0, err[k]}, {31'd0, e.err});
                        chk("resp_rdata", k, rdata[k], e.rdata);
                    end
                end else begin
                    chk("idle_rvalid", k, {31'd0, rvalid[k]}, 32'd0);
                    chk("idle_rdata", k, rdata[k], 32'h0000_0000);
                    chk("idle_err", k, {31'd0, err[k]}, 32'd0);
                    if (sb_q[k].size() > 0 && sb_q[k][0].due <= cyc) begin
                        chk("missing_rvalid", k, 32'd0, 32'd1);
                        void'(sb_q[k].pop_front());
                    end
                end
                if (rst_n && gnt[k] === 1'b1) model_push(k);
                chk("outstanding_bound", k, {31'd0, sb_q[k].size() <= maxo_of(k)}, 32'd1);
                if (!rst_n) sb_q[k].delete();
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until granted; waited = cycles without grant.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, output int waited);
        int n;
        n = 0;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        forever begin
            @(negedge clk);
            if (gnt[k] === 1'b1) break;
            n++;
            if (n > 50) begin
                chk("gnt_timeout", k, 32'(n), 32'd50);
                break;
            end
        end
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        waited = n;
    endtask

    task automatic rand_ops(input int k, input int count);
        bit done;
        done = 1'b0;
        fork
            begin
                int w;
                logic [31:0] a;
                for (int i = 0; i < count; i++) begin
                    int r;
                    r = $urandom_range(0, 9);
                    if (r == 0)      a = 32'($urandom_range(0, 32'h000F_FFFF));
                    else if (r == 1) a = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 4095));
                    else             a = pool_addr($urandom_range(0, 8)) | 32'($urandom_range(0, 3));
                    xfer(k, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    stall[k] = ($urandom_range(0, 3) == 0);
                    @(posedge clk);
                    #1;
                end
                stall[k] = 1'b0;
            end
        join
    endtask

    initial begin
        int w;
        cyc = 0; comp_cnt = 0; fail_cnt = 0; armed = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stall[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 32'h0; be[k] = 4'h0; wdata[k] = 32'h0;
        end
        @(posedge clk);
        #1 armed = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Fill the address pool of both instances so every later load is defined.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) xfer(k, 1'b1, pool_addr(i), 4'hF, $urandom, w);
        end
        idle(5);

        // Full-word store then load, both granted immediately.
        xfer(0, 1'b1, 32'h0010_0010, 4'hF, 32'hDEAD_BEEF, w);
        chk("store_gnt_wait", 0, 32'(w), 32'd0);
        xfer(0, 1'b0, 32'h0010_0010, 4'h0, 32'h0, w);
        chk("load_gnt_wait", 0, 32'(w), 32'd0);
        // Single-lane store merges into the word.
        xfer(0, 1'b1, 32'h0010_0010, 4'b0010, 32'h0000_AA00, w);
        xfer(0, 1'b0, 32'h0010_0010, 4'hF, 32'h0, w);
        // Below and just above the window, then the last valid word.
        xfer(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, w);
        xfer(0, 1'b1, BASE + 32'(4 * WORDS), 4'hF, 32'h1234_5678, w);
        xfer(0, 1'b0, pool_addr(8), 4'hF, 32'h0, w);
        idle(3);

        // Back-to-back loads with default parameters: no stall cycles.
        for (int i = 0; i < 6; i++) begin
            xfer(0, 1'b0, pool_addr(i), 4'hF, 32'h0, w);
            chk("b2b_gnt_wait", 0, 32'(w), 32'd0);
        end
        idle(3);

        // Stall holds the grant off for 4 cycles; grant the cycle it drops.
        stall[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = pool_addr(2); be[0] = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_gnt", 0, {31'd0, gnt[0]}, 32'd0);
        end
        @(posedge clk);
        #1 stall[0] = 1'b0;
        @(negedge clk);
        chk("stall_release_gnt", 0, {31'd0, gnt[0]}, 32'd1);
        @(posedge clk);
        #1 req[0] = 1'b0;
        idle(2);
        rand_ops(0, 60);
        idle(5);

        // Latency 3, one outstanding: grants every third cycle.
        xfer(1, 1'b0, pool_addr(0), 4'hF, 32'h0, w);
        chk("l3_first_wait", 1, 32'(w), 32'd0);
        xfer(1, 1'b0, pool_addr(1), 4'hF, 32'h0, w);
        chk("l3_second_wait", 1, 32'(w), 32'd2);
        xfer(1, 1'b0, pool_addr(8), 4'hF, 32'h0, w);
        chk("l3_third_wait", 1, 32'(w), 32'd2);
        idle(5);

        // Reset one cycle after a grant drops the in-flight response.
        xfer(1, 1'b0, pool_addr(3), 4'hF, 32'h0, w);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(6);
        xfer(1, 1'b0, pool_addr(3), 4'hF, 32'h0, w);
        chk("post_reset_gnt_wait", 1, 32'(w), 32'd0);
        idle(5);
        rand_ops(1, 40);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
